// File: rtl/frv_dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   - arb_state_e : arbiter FSM encodings (ARB_IDLE / ARB_HOLD)
//   - ARB_PORT_A/B: requester ids carried through the routing FIFO
//   - STRB_W      : byte-strobe width of every request channel
//   - arb_pick    : round-robin choice between two requesters
package frv_dmem_arbiter_pkg;

  localparam int STRB_W = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  localparam logic ARB_PORT_A = 1'b0;
  localparam logic ARB_PORT_B = 1'b1;

  // A lone requester always wins; on a tie the port that was not granted
  // most recently wins. With no request the result is A and is ignored.
  function automatic logic arb_pick(input logic a_req, input logic b_req,
                                    input logic last_grant);
    if (a_req && b_req) return ~last_grant;
    else if (b_req)     return ARB_PORT_B;
    else                return ARB_PORT_A;
  endfunction

endpackage

// File: rtl/frv_dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//   a_* / b_* : requester channels (req, wen, strb, wdata, addr in;
//               gnt, recv, rdata, error back)
//   dmem_*    : shared downstream memory port
// Handshake: a request is issued when req=1; it is accepted in the cycle
// gnt=1 (req & gnt). A requester keeps req and all request fields stable
// until it sees gnt. Responses come back in issue order as one-cycle recv
// pulses with rdata/error valid in that same cycle; there is no back-pressure
// on responses.
// Modports: slave = arbiter view, master = requesters + memory view.
interface frv_dmem_arbiter_if
  import frv_dmem_arbiter_pkg::*;
#(
  parameter int AW = 32
);
  logic              a_req, a_wen, a_gnt, a_recv, a_error;
  logic [STRB_W-1:0] a_strb;
  logic [AW-1:0]     a_wdata, a_addr, a_rdata;

  logic              b_req, b_wen, b_gnt, b_recv, b_error;
  logic [STRB_W-1:0] b_strb;
  logic [AW-1:0]     b_wdata, b_addr, b_rdata;

  logic              dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_error;
  logic [STRB_W-1:0] dmem_strb;
  logic [AW-1:0]     dmem_wdata, dmem_addr, dmem_rdata;

  modport slave (
    input  a_req, a_wen, a_strb, a_wdata, a_addr,
    output a_gnt, a_recv, a_rdata, a_error,
    input  b_req, b_wen, b_strb, b_wdata, b_addr,
    output b_gnt, b_recv, b_rdata, b_error,
    output dmem_req, dmem_wen, dmem_strb, dmem_wdata, dmem_addr,
    input  dmem_gnt, dmem_recv, dmem_rdata, dmem_error
  );

  modport master (
    output a_req, a_wen, a_strb, a_wdata, a_addr,
    input  a_gnt, a_recv, a_rdata, a_error,
    output b_req, b_wen, b_strb, b_wdata, b_addr,
    input  b_gnt, b_recv, b_rdata, b_error,
    input  dmem_req, dmem_wen, dmem_strb, dmem_wdata, dmem_addr,
    output dmem_gnt, dmem_recv, dmem_rdata, dmem_error
  );

endinterface

// File: rtl/frv_dmem_route_fifo.sv
// In-order routing FIFO, one bit wide: remembers which requester issued
// each outstanding memory transaction.
//   clk, rst      : clock, asynchronous active-high reset
//   push, push_id : write push_id at the tail (ignored when full)
//   pop           : drop the head entry (ignored when empty)
//   head          : id at the head
//   full, empty   : occupancy flags
//   count         : number of stored entries (0..DEPTH)
module frv_dmem_route_fifo #(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          push_id,
  input  logic          pop,
  output logic          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Explicit wrap so non-power-of-two depths and DEPTH=1 still behave.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frv_dmem_arbiter.sv
// Two-port data-memory arbiter: shares one memory request/response port
// between the execute-stage LSU (port A) and a secondary master (port B).
//   g_clk, g_reset  : clock, asynchronous active-high reset
//   bus             : requester and memory channels (slave modport)
//   spurious_rsp    : sticky, a response arrived with nothing outstanding
//   dbg_state       : arbiter FSM state
//   dbg_outstanding : issued-but-unanswered transaction count
// Round-robin selection; a presented but not yet accepted request is locked
// (ARB_HOLD) until the memory grants it. Grants and responses are routed
// combinationally with zero added latency.
module frv_dmem_arbiter
  import frv_dmem_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int AW              = 32
) (
  input  logic                              g_clk,
  input  logic                              g_reset,
  frv_dmem_arbiter_if.slave                 bus,
  output logic                              spurious_rsp,
  output arb_state_e                        dbg_state,
  output logic [$clog2(MAX_OUTSTANDING):0]  dbg_outstanding
);

  arb_state_e state;
  logic       last_grant, lock;
  logic       sel, active, active_req, issue, grant, pop;
  logic       fifo_head, fifo_full, fifo_empty;
  logic [AW-1:0] rsp_data;

  assign sel        = arb_pick(bus.a_req, bus.b_req, last_grant);
  assign active     = (state == ARB_HOLD) ? lock : sel;
  assign active_req = (active == ARB_PORT_A) ? bus.a_req : bus.b_req;
  // The full check uses registered occupancy only, so a same-cycle pop
  // never opens a slot. In HOLD the FIFO cannot be full (HOLD is only
  // entered with room and nothing is pushed until it leaves).
  assign issue = ~g_reset & active_req & ((state == ARB_HOLD) | ~fifo_full);
  assign grant = issue & bus.dmem_gnt;
  // Outputs are forced low while reset is held.
  assign pop   = ~g_reset & bus.dmem_recv & ~fifo_empty;

  assign rsp_data = bus.dmem_rdata;

  always_comb begin
    bus.dmem_req   = issue;
    bus.dmem_wen   = 1'b0;
    bus.dmem_strb  = '0;
    bus.dmem_wdata = '0;
    bus.dmem_addr  = '0;
    if (issue) begin
      if (active == ARB_PORT_A) begin
        bus.dmem_wen   = bus.a_wen;
        bus.dmem_strb  = bus.a_strb;
        bus.dmem_wdata = bus.a_wdata;
        bus.dmem_addr  = bus.a_addr;
      end else begin
        bus.dmem_wen   = bus.b_wen;
        bus.dmem_strb  = bus.b_strb;
        bus.dmem_wdata = bus.b_wdata;
        bus.dmem_addr  = bus.b_addr;
      end
    end
  end

  assign bus.a_gnt   = grant & (active == ARB_PORT_A);
  assign bus.b_gnt   = grant & (active == ARB_PORT_B);
  assign bus.a_recv  = pop & (fifo_head == ARB_PORT_A);
  assign bus.b_recv  = pop & (fifo_head == ARB_PORT_B);
  assign bus.a_rdata = bus.a_recv ? rsp_data : '0;
  assign bus.b_rdata = bus.b_recv ? rsp_data : '0;
  assign bus.a_error = bus.a_recv & bus.dmem_error;
  assign bus.b_error = bus.b_recv & bus.dmem_error;

  frv_dmem_route_fifo #(.DEPTH(MAX_OUTSTANDING)) u_route_fifo (
    .clk     (g_clk),
    .rst     (g_reset),
    .push    (grant),
    .push_id (active),
    .pop     (pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (dbg_outstanding)
  );

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state        <= ARB_IDLE;
      last_grant   <= ARB_PORT_B;
      lock         <= ARB_PORT_A;
      spurious_rsp <= 1'b0;
    end else begin
      if (bus.dmem_recv && fifo_empty) spurious_rsp <= 1'b1;
      case (state)
        ARB_IDLE: begin
          if (issue) begin
            if (bus.dmem_gnt) begin
              last_grant <= sel;
            end else begin
              lock  <= sel;
              state <= ARB_HOLD;
            end
          end
        end
        ARB_HOLD: begin
          // A locked requester that withdraws simply releases the lock.
          if (!active_req) begin
            state <= ARB_IDLE;
          end else if (bus.dmem_gnt) begin
            last_grant <= lock;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
module tb_frv_dmem_arbiter;
  import frv_dmem_arbiter_pkg::*;

  localparam int AW   = 32;
  localparam int MAXO = 2;
  localparam logic A = 1'b0;
  localparam logic B = 1'b1;

  // ---------------- clock / reset ----------------
  logic       g_clk = 1'b0;
  logic       g_reset;
  logic       spurious_rsp;
  arb_state_e dbg_state;
  logic [$clog2(MAXO):0] dbg_outstanding;

  always #5 g_clk = ~g_clk;

  frv_dmem_arbiter_if #(.AW(AW)) bus ();

  frv_dmem_arbiter #(.MAX_OUTSTANDING(MAXO), .AW(AW)) dut (
    .g_clk           (g_clk),
    .g_reset         (g_reset),
    .bus             (bus),
    .spurious_rsp    (spurious_rsp),
    .dbg_state       (dbg_state),
    .dbg_outstanding (dbg_outstanding)
  );

  int n_cmp = 0;
  int n_err = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- vector record ----------------
  typedef struct {
    logic ar, br;
    logic [AW-1:0] aa, ba;
    logic g, rv;
    logic [AW-1:0] rd;
    logic er;
    logic dq, ep;
    logic [AW-1:0] da;
    logic ag, bg, arc, brc, sp;
  } vec_t;

  // Per-port request payload (besides address) currently presented.
  logic          a_wen_v, b_wen_v;
  logic [3:0]    a_strb_v, b_strb_v;
  logic [AW-1:0] a_wd_v, b_wd_v;

  function automatic vec_t mk(input logic ar, input logic br,
                              input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                              input logic g, input logic rv,
                              input logic [AW-1:0] rd, input logic er,
                              input logic dq, input logic ep,
                              input logic [AW-1:0] da,
                              input logic ag, input logic bg,
                              input logic arc, input logic brc, input logic sp);
    vec_t v;
    v.ar = ar; v.br = br; v.aa = aa; v.ba = ba; v.g = g; v.rv = rv;
    v.rd = rd; v.er = er; v.dq = dq; v.ep = ep; v.da = da;
    v.ag = ag; v.bg = bg; v.arc = arc; v.brc = brc; v.sp = sp;
    return v;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [AW-1:0] act,
                       input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.a_req = 0; bus.a_wen = 0; bus.a_strb = '0; bus.a_wdata = '0; bus.a_addr = '0;
    bus.b_req = 0; bus.b_wen = 0; bus.b_strb = '0; bus.b_wdata = '0; bus.b_addr = '0;
    bus.dmem_gnt = 0; bus.dmem_recv = 0; bus.dmem_rdata = '0; bus.dmem_error = 0;
  endtask

  task automatic do_reset();
    g_reset = 1'b1;
    idle_inputs();
    @(posedge g_clk); #1;
    g_reset = 1'b0;
  endtask

  // Drive one cycle, compare at the falling edge, advance past the rising edge.
  task automatic apply_row(input vec_t v, input string tag);
    bus.a_req = v.ar; bus.a_addr = v.aa; bus.a_wen = a_wen_v;
    bus.a_strb = a_strb_v; bus.a_wdata = a_wd_v;
    bus.b_req = v.br; bus.b_addr = v.ba; bus.b_wen = b_wen_v;
    bus.b_strb = b_strb_v; bus.b_wdata = b_wd_v;
    bus.dmem_gnt = v.g; bus.dmem_recv = v.rv;
    bus.dmem_rdata = v.rd; bus.dmem_error = v.er;
    @(negedge g_clk);
    check($sformatf("%s dmem_req", tag), bus.dmem_req, v.dq);
    if (v.dq) begin
      check($sformatf("%s dmem_addr", tag), bus.dmem_addr, v.da);
      check($sformatf("%s dmem_wdata", tag), bus.dmem_wdata, v.ep ? b_wd_v : a_wd_v);
      check($sformatf("%s dmem_wen", tag), bus.dmem_wen, v.ep ? b_wen_v : a_wen_v);
      check($sformatf("%s dmem_strb", tag), bus.dmem_strb, v.ep ? b_strb_v : a_strb_v);
    end
    check($sformatf("%s a_gnt", tag), bus.a_gnt, v.ag);
    check($sformatf("%s b_gnt", tag), bus.b_gnt, v.bg);
    check($sformatf("%s a_recv", tag), bus.a_recv, v.arc);
    check($sformatf("%s b_recv", tag), bus.b_recv, v.brc);
    check($sformatf("%s a_rdata", tag), bus.a_rdata, v.arc ? v.rd : '0);
    check($sformatf("%s b_rdata", tag), bus.b_rdata, v.brc ? v.rd : '0);
    check($sformatf("%s a_error", tag), bus.a_error, v.arc & v.er);
    check($sformatf("%s b_error", tag), bus.b_error, v.brc & v.er);
    check($sformatf("%s spurious_rsp", tag), spurious_rsp, v.sp);
    @(posedge g_clk); #1;
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[$];

  // Reference model state for the random phase.
  logic [0:0]    exp_q[$];
  logic          last_m, hold_m, hold_port;
  logic          pa, pb;
  logic [AW-1:0] a_addr_m, b_addr_m;

  initial begin
    // fixed payloads for directed tests
    a_wen_v = 1'b0; a_strb_v = 4'hF; a_wd_v = 32'hAAAA0001;
    b_wen_v = 1'b1; b_strb_v = 4'h3; b_wd_v = 32'hBBBB0002;

    // Reset state: outputs low even with activity on the inputs.
    g_reset = 1'b1;
    idle_inputs();
    bus.a_req = 1; bus.b_req = 1; bus.dmem_gnt = 1; bus.dmem_recv = 1;
    @(negedge g_clk);
    check("reset dmem_req", bus.dmem_req, 1'b0);
    check("reset a_gnt", bus.a_gnt, 1'b0);
    check("reset b_gnt", bus.b_gnt, 1'b0);
    check("reset a_recv", bus.a_recv, 1'b0);
    check("reset b_recv", bus.b_recv, 1'b0);
    check("reset spurious_rsp", spurious_rsp, 1'b0);
    check("reset state", 32'(dbg_state), 32'(ARB_IDLE));
    @(posedge g_clk); #1;
    idle_inputs();
    g_reset = 1'b0;

    //                ar br aa          ba          g  rv rd            er  dq ep da           ag bg arc brc sp
    // A-only read, response two cycles later
    vecs.push_back(mk(1, 0, 32'h100,    32'h0,      1, 0, 32'h0,        0,  1, A, 32'h100,   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,      32'h0,      0, 0, 32'h0,        0,  0, A, 32'h0,     0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,      32'h0,      0, 1, 32'hDEADBEEF, 0,  0, A, 32'h0,     0, 0, 1, 0, 0));
    // contention after A was last granted: B, A, B
    vecs.push_back(mk(1, 1, 32'h104,    32'h200,    1, 0, 32'h0,        0,  1, B, 32'h200,   0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h104,    32'h200,    1, 1, 32'h11111111, 0,  1, A, 32'h104,   1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 32'h108,    32'h200,    1, 1, 32'h22222222, 0,  1, B, 32'h200,   0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,      32'h0,      0, 1, 32'h33333333, 1,  0, A, 32'h0,     0, 0, 0, 1, 0));
    // B locked for three stalled cycles while A joins
    vecs.push_back(mk(0, 1, 32'h0,      32'h208,    0, 0, 32'h0,        0,  1, B, 32'h208,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h10C,    32'h208,    0, 0, 32'h0,        0,  1, B, 32'h208,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h10C,    32'h208,    0, 0, 32'h0,        0,  1, B, 32'h208,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h10C,    32'h208,    1, 0, 32'h0,        0,  1, B, 32'h208,   0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h10C,    32'h0,      1, 0, 32'h0,        0,  1, A, 32'h10C,   1, 0, 0, 0, 0));
    // FIFO full: no issue, not even on a same-cycle pop
    vecs.push_back(mk(1, 0, 32'h110,    32'h0,      1, 0, 32'h0,        0,  0, A, 32'h0,     0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h110,    32'h0,      1, 1, 32'h44444444, 0,  0, A, 32'h0,     0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 32'h110,    32'h0,      1, 1, 32'h55555555, 0,  1, A, 32'h110,   1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,      32'h0,      0, 1, 32'h66666666, 0,  0, A, 32'h0,     0, 0, 1, 0, 0));
    // response with nothing outstanding: dropped, sticky flag
    vecs.push_back(mk(0, 0, 32'h0,      32'h0,      0, 1, 32'h77777777, 1,  0, A, 32'h0,     0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,      32'h0,      0, 0, 32'h0,        0,  0, A, 32'h0,     0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 32'h114,    32'h0,      1, 0, 32'h0,        0,  1, A, 32'h114,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,      32'h0,      0, 1, 32'h88888888, 0,  0, A, 32'h0,     0, 0, 1, 0, 1));
    // locked B withdraws: request drops with it, lock released
    vecs.push_back(mk(0, 1, 32'h0,      32'h20C,    0, 0, 32'h0,        0,  1, B, 32'h20C,   0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 32'h118,    32'h0,      1, 0, 32'h0,        0,  0, A, 32'h0,     0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 32'h118,    32'h0,      1, 0, 32'h0,        0,  1, A, 32'h118,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,      32'h0,      0, 1, 32'h99999999, 1,  0, A, 32'h0,     0, 0, 1, 0, 1));

    foreach (vecs[i]) apply_row(vecs[i], $sformatf("vec%0d", i));

    // ---- alternation from reset: A,B,A,B..., responses one cycle later ----
    do_reset();
    begin
      logic p, q;
      q = A;
      for (int i = 0; i < 6; i++) begin
        logic [AW-1:0] aa, ba;
        p  = (i % 2 == 1) ? B : A;
        aa = 32'h300 + 32'(i * 4);
        ba = 32'h400 + 32'(i * 4);
        apply_row(mk(1, 1, aa, ba, 1, (i > 0), 32'hC0DE0000 + 32'(i), 0,
                     1, p, p ? ba : aa, p == A, p == B,
                     (i > 0) && (q == A), (i > 0) && (q == B), 0),
                  $sformatf("alt%0d", i));
        q = p;
      end
      apply_row(mk(0, 0, 32'h0, 32'h0, 0, 1, 32'hC0DE0006, 0,
                   0, A, 32'h0, 0, 0, q == A, q == B, 0), "alt_last");
    end

    // ---- reset while holding with one transaction outstanding ----
    do_reset();
    apply_row(mk(1, 0, 32'h500, 32'h0, 1, 0, 32'h0, 0, 1, A, 32'h500, 1, 0, 0, 0, 0), "rst0");
    apply_row(mk(0, 1, 32'h0, 32'h600, 0, 0, 32'h0, 0, 1, B, 32'h600, 0, 0, 0, 0, 0), "rst1");
    check("rst hold state", 32'(dbg_state), 32'(ARB_HOLD));
    bus.a_req = 1; bus.dmem_gnt = 1; bus.dmem_recv = 1;
    g_reset = 1'b1;
    #1;
    check("rst mid dmem_req", bus.dmem_req, 1'b0);
    check("rst mid a_gnt", bus.a_gnt, 1'b0);
    check("rst mid b_gnt", bus.b_gnt, 1'b0);
    check("rst mid a_recv", bus.a_recv, 1'b0);
    check("rst mid b_recv", bus.b_recv, 1'b0);
    check("rst mid state", 32'(dbg_state), 32'(ARB_IDLE));
    check("rst mid outstanding", 32'(dbg_outstanding), 32'h0);
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    apply_row(mk(0, 0, 32'h0, 32'h0, 0, 1, 32'h0BAD0BAD, 1, 0, A, 32'h0, 0, 0, 0, 0, 0), "rst2");
    apply_row(mk(1, 1, 32'h504, 32'h604, 1, 0, 32'h0, 0, 1, A, 32'h504, 1, 0, 0, 0, 1), "rst3");

    // ---- randomized traffic against a transaction-level model ----
    do_reset();
    exp_q.delete();
    last_m = B; hold_m = 0; hold_port = A; pa = 0; pb = 0;
    a_addr_m = '0; b_addr_m = '0;
    for (int c = 0; c < 400; c++) begin
      logic g, rv, er, want_v, want_p, front;
      logic [AW-1:0] rd;
      if (!pa && $urandom_range(0, 2) == 0) begin
        pa = 1; a_addr_m = $urandom; a_wd_v = $urandom;
        a_wen_v = 1'($urandom_range(0, 1)); a_strb_v = 4'($urandom_range(0, 15));
      end
      if (!pb && $urandom_range(0, 2) == 0) begin
        pb = 1; b_addr_m = $urandom; b_wd_v = $urandom;
        b_wen_v = 1'($urandom_range(0, 1)); b_strb_v = 4'($urandom_range(0, 15));
      end
      g  = 1'($urandom_range(0, 1));
      rv = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
      rd = $urandom;
      er = 1'($urandom_range(0, 1));
      // A presented-but-unaccepted request must be served first; otherwise
      // nothing issues while MAXO transactions are unanswered.
      want_v = 0; want_p = A;
      if (hold_m) begin
        want_v = 1; want_p = hold_port;
      end else if (exp_q.size() < MAXO) begin
        if (pa && pb)  begin want_v = 1; want_p = ~last_m; end
        else if (pa)   begin want_v = 1; want_p = A; end
        else if (pb)   begin want_v = 1; want_p = B; end
      end
      front = rv ? exp_q[0] : A;
      apply_row(mk(pa, pb, a_addr_m, b_addr_m, g, rv, rd, er,
                   want_v, want_p, want_p ? b_addr_m : a_addr_m,
                   want_v && g && (want_p == A), want_v && g && (want_p == B),
                   rv && (front == A), rv && (front == B), 0),
                $sformatf("rnd%0d", c));
      if (rv) void'(exp_q.pop_front());
      if (want_v && g) begin
        exp_q.push_back(want_p);
        last_m = want_p;
        hold_m = 0;
        if (want_p == A) pa = 0; else pb = 0;
      end else if (want_v) begin
        hold_m = 1; hold_port = want_p;
      end
    end
    check("rnd outstanding", 32'(dbg_outstanding), 32'(exp_q.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frv_dmem_arbiter.md
Name: frv_dmem_arbiter

Overview:
- Shares the single core data-memory port (req/gnt request channel, recv response channel) between two requesters.
- Port A is the execute-stage LSU; port B is a secondary master (debug / coprocessor).
- Round-robin arbitration with request locking until grant.
- A small in-order routing FIFO steers each memory response back to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered transactions (routing FIFO depth, power of two, ≥1).
- AW, 32, address and data width.

Ports:
- g_clk  input  1  global clock
- g_reset  input  1  asynchronous active-high reset
- a_req  input  1  port A request; held with fields stable until a_gnt
- a_wen  input  1  port A write enable
- a_strb  input  4  port A write strobe
- a_wdata  input  AW  port A write data
- a_addr  input  AW  port A address
- a_gnt  output  1  port A request accepted
- a_recv  output  1  port A response valid
- a_rdata  output  AW  port A read data
- a_error  output  1  port A bus error
- b_req, b_wen, b_strb, b_wdata, b_addr  inputs  as port A  port B request channel
- b_gnt, b_recv, b_rdata, b_error  outputs  as port A  port B handshake/response
- dmem_req  output  1  downstream request
- dmem_wen  output  1  downstream write enable
- dmem_strb  output  4  downstream strobe
- dmem_wdata  output  AW  downstream write data
- dmem_addr  output  AW  downstream address
- dmem_gnt  input  1  downstream accepted request
- dmem_recv  input  1  downstream response valid
- dmem_rdata  input  AW  downstream read data
- dmem_error  input  1  downstream bus error
- spurious_rsp  output  1  sticky: dmem_recv seen with no outstanding transaction

Behaviour:
- Reset (async, g_reset=1):
  - FSM=ARB_IDLE, last_grant=B (so A wins first tie), FIFO empty, spurious_rsp=0.
  - All outputs 0 while reset is held.
- FSM ARB_IDLE:
  - Selection is combinational among asserted a_req/b_req.
  - Single requester wins. When both request, the port not equal to last_grant wins.
  - If the FIFO is full: dmem_req=0, no gnt.
  - Otherwise dmem_req=1 with the selected port's fields muxed out.
  - dmem_gnt same cycle: push selected id, last_grant<=sel, stay ARB_IDLE.
  - No dmem_gnt: latch sel into lock, go ARB_HOLD.
- FSM ARB_HOLD:
  - Drive the locked port only, regardless of the other port's req.
  - dmem_req=1 (FIFO cannot fill while holding).
  - On dmem_gnt: push lock id, last_grant<=lock, go ARB_IDLE.
  - If the locked requester drops req (protocol violation): dmem_req follows it to 0 and the FSM returns to ARB_IDLE.
- Grant routing: a_gnt = dmem_req & dmem_gnt & (active==A); b_gnt likewise. Zero-cycle latency, no registered gnt.
- Request latency: a single uncontended request issues in the same cycle.
- Unselected port's outputs: gnt=0, recv=0, rdata=0, error=0.
- FIFO full: no new issue, even if dmem_recv pops in the same cycle. The push decision depends only on registered state.
- Response routing:
  - On dmem_recv with the FIFO non-empty: pop head, assert head port's recv, pass rdata and error through combinationally.
  - On dmem_recv with the FIFO empty: drop the response, set spurious_rsp (cleared only by reset).
- Simultaneous push and pop (FIFO not full): both occur; count unchanged.
- Pointers wrap modulo MAX_OUTSTANDING. A count register of width clog2(MAX_OUTSTANDING)+1 distinguishes full from empty.
- Reset mid-transaction: lock and FIFO are lost. Responses arriving afterwards are dropped and flagged spurious_rsp.

Decomposition:
- Shared include/package holds:
  - ARB_IDLE/ARB_HOLD state encodings
  - port id constants ARB_PORT_A=1'b0, ARB_PORT_B=1'b1
  - strobe width constant
- One sub-module: frv_dmem_route_fifo (1-bit-wide sync FIFO with push, pop, head, full, empty, count; async active-high reset).

Test Plan:
- A-only read at addr 0x100, dmem_gnt same cycle, recv 2 cycles later with rdata 0xDEADBEEF -> a_gnt in cycle 0, a_recv with 0xDEADBEEF, b_* all 0.
- A and B both request every cycle, dmem_gnt=1 always, responses returned next cycle -> grants alternate A,B,A,B starting with A after reset; each recv goes to its issuer.
- B requests with dmem_gnt low for 3 cycles while A asserts in cycle 1 -> dmem_addr stays B's for all cycles, b_gnt in cycle 3, A granted in cycle 4.
- MAX_OUTSTANDING=2: two grants, no responses, third A request -> dmem_req=0 until a recv pops. A dmem_recv in the same cycle as the full condition still blocks the issue that cycle.
- dmem_recv with FIFO empty and dmem_error=1 -> no port recv, spurious_rsp=1 and stays 1 until g_reset.
- Assert g_reset during ARB_HOLD with one transaction outstanding -> all outputs 0 immediately. After release, A wins first contention and a stale recv sets spurious_rsp.
